// File: rtl/lcd_sched_pkg.sv
// Shared encodings for the LCD character scheduler: FIFO entry format,
// emitter states and ASCII constants.
package lcd_sched_pkg;

  typedef enum logic [1:0] {
    OP_CHAR = 2'd0,
    OP_NL   = 2'd1
  } op_e;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam int         ROW_LEN_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    GAP    = 2'd2,
    CLR    = 2'd3
  } emit_state_e;

  typedef struct packed {
    op_e        op;
    logic [7:0] data;
  } fifo_entry_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_op_fifo.sv
// Synchronous FIFO for queued LCD ops; flush empties it in one cycle.
module lcd_op_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/lcd_char_scheduler.sv
// Round-robin merge of two character sources into a FIFO, drained by an
// emitter that produces spaced char/transfer/clear strobes for the LCD.
module lcd_char_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int ROW_LEN      = ROW_LEN_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          src0_valid,
  input  logic [7:0]                    src0_data,
  output logic                          src0_ready,
  input  logic                          src1_valid,
  input  logic [7:0]                    src1_data,
  output logic                          src1_ready,
  input  logic                          newline_req,
  input  logic                          clear_req,
  output logic [7:0]                    char_in,
  output logic                          char_valid,
  output logic                          char_to_row2,
  output logic                          transfer_to_row1,
  output logic                          clear,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [$clog2(ROW_LEN):0]      row2_col
);

  localparam int RCW   = $clog2(ROW_LEN) + 1;
  localparam int CNT_W = $clog2(max2(PULSE_CYCLES, GAP_CYCLES)) + 1;

  logic        fifo_full, fifo_empty, push, pop;
  fifo_entry_t push_entry, head;

  logic        prio_q, prio_d;
  logic        grant0, grant1, accept_ok;

  emit_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             char_valid_q, char_valid_d;
  logic             xfer_q, xfer_d;
  logic             clear_q, clear_d;
  logic [7:0]       char_in_q, char_in_d;
  logic [RCW-1:0]   row2_col_q, row2_col_d;

  lcd_op_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clear_req),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // prio_q==0 favours src0 when both sources are valid.
  assign grant0     = src0_valid && (!src1_valid || !prio_q);
  assign grant1     = src1_valid && (!src0_valid ||  prio_q);
  assign accept_ok  = !rst && !clear_req && !fifo_full && !newline_req;
  assign src0_ready = accept_ok && grant0;
  assign src1_ready = accept_ok && grant1;

  always_comb begin
    prio_d          = prio_q;
    push            = 1'b0;
    push_entry.op   = OP_CHAR;
    push_entry.data = 8'h00;
    if (newline_req && !rst && !clear_req && !fifo_full) begin
      push            = 1'b1;
      push_entry.op   = OP_NL;
      push_entry.data = ASCII_LF;
    end else if (src0_ready) begin
      push            = 1'b1;
      push_entry.op   = (src0_data == ASCII_LF) ? OP_NL : OP_CHAR;
      push_entry.data = src0_data;
      prio_d          = 1'b1;
    end else if (src1_ready) begin
      push            = 1'b1;
      push_entry.op   = (src1_data == ASCII_LF) ? OP_NL : OP_CHAR;
      push_entry.data = src1_data;
      prio_d          = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    char_valid_d = char_valid_q;
    xfer_d       = xfer_q;
    clear_d      = clear_q;
    char_in_d    = char_in_q;
    row2_col_d   = row2_col_q;
    pop          = 1'b0;
    if (clear_req) begin
      state_d      = CLR;
      cnt_d        = '0;
      clear_d      = 1'b1;
      char_valid_d = 1'b0;
      xfer_d       = 1'b0;
      row2_col_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            if (head.op == OP_CHAR) begin
              cnt_d   = '0;
              state_d = STROBE;
              if (row2_col_q == RCW'(ROW_LEN)) begin
                // Row full: move it up first, keep the char queued.
                xfer_d     = 1'b1;
                row2_col_d = '0;
              end else begin
                pop          = 1'b1;
                char_in_d    = head.data;
                char_valid_d = 1'b1;
                row2_col_d   = row2_col_q + 1'b1;
              end
            end else begin
              pop = 1'b1;
              if (row2_col_q != '0) begin
                xfer_d     = 1'b1;
                row2_col_d = '0;
                cnt_d      = '0;
                state_d    = STROBE;
              end
            end
          end
        end
        STROBE, CLR: begin
          if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
            char_valid_d = 1'b0;
            xfer_d       = 1'b0;
            clear_d      = 1'b0;
            cnt_d        = '0;
            // The IDLE decision cycle is the last low cycle of the gap.
            state_d      = (GAP_CYCLES > 1) ? GAP : IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (int'(cnt_q) >= GAP_CYCLES - 2) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q       <= 1'b0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      char_valid_q <= 1'b0;
      xfer_q       <= 1'b0;
      clear_q      <= 1'b0;
      char_in_q    <= 8'h00;
      row2_col_q   <= '0;
    end else begin
      prio_q       <= prio_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      char_valid_q <= char_valid_d;
      xfer_q       <= xfer_d;
      clear_q      <= clear_d;
      char_in_q    <= char_in_d;
      row2_col_q   <= row2_col_d;
    end
  end

  assign char_in          = char_in_q;
  assign char_valid       = char_valid_q;
  assign transfer_to_row1 = xfer_q;
  assign clear            = clear_q;
  assign char_to_row2     = 1'b1;
  assign row2_col         = row2_col_q;
  assign busy             = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_lcd_char_scheduler.sv
// Directed bench for lcd_char_scheduler: strobe timing, arbitration order,
// row wrap, newline handling, FIFO backpressure and clear behaviour.
module tb_lcd_char_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       src0_valid, src1_valid, newline_req, clear_req;
  logic [7:0] src0_data, src1_data;
  logic       src0_ready, src1_ready;
  logic [7:0] char_in;
  logic       char_valid, char_to_row2, transfer_to_row1, clear, busy;
  logic [3:0] fifo_count;
  logic [4:0] row2_col;

  int vectors = 0;
  int miscompares = 0;

  logic [9:0] ev_q[$];
  logic       cv_prev = 1'b0, tr_prev = 1'b0, cl_prev = 1'b0;

  always #5 clk = ~clk;

  lcd_char_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .src0_valid       (src0_valid),
    .src0_data        (src0_data),
    .src0_ready       (src0_ready),
    .src1_valid       (src1_valid),
    .src1_data        (src1_data),
    .src1_ready       (src1_ready),
    .newline_req      (newline_req),
    .clear_req        (clear_req),
    .char_in          (char_in),
    .char_valid       (char_valid),
    .char_to_row2     (char_to_row2),
    .transfer_to_row1 (transfer_to_row1),
    .clear            (clear),
    .busy             (busy),
    .fifo_count       (fifo_count),
    .row2_col         (row2_col)
  );

  // Event log of strobe rising edges: {kind, char}; 1=char, 2=transfer, 3=clear.
  always @(posedge clk) begin
    if (char_valid && !cv_prev)       ev_q.push_back({2'd1, char_in});
    if (transfer_to_row1 && !tr_prev) ev_q.push_back({2'd2, 8'h00});
    if (clear && !cl_prev)            ev_q.push_back({2'd3, 8'h00});
    cv_prev <= char_valid;
    tr_prev <= transfer_to_row1;
    cl_prev <= clear;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ev_at(input int i);
    if (i < ev_q.size()) return ev_q[i];
    return 10'h3FF;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    src0_valid = 0; src1_valid = 0; newline_req = 0; clear_req = 0;
    src0_data = 8'h00; src1_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    ev_q.delete();
  endtask

  task automatic send(input bit which, input logic [7:0] d);
    bit ok = 1'b0;
    if (which) begin src1_valid = 1'b1; src1_data = d; end
    else begin src0_valid = 1'b1; src0_data = d; end
    for (int i = 0; i < 300; i++) begin
      #1;
      if ((which ? src1_ready : src0_ready) == 1'b1) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    chk("send_handshake", ok, 1);
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_idle", ok, 1);
  endtask

  initial begin
    int  k;
    bit  seen_full, seen_re, got6;

    // Reset state, with src0 valid while reset is held
    rst = 1'b1;
    src0_valid = 1'b1; src0_data = 8'h41;
    src1_valid = 0; src1_data = 0; newline_req = 0; clear_req = 0;
    tick();
    tick();
    chk("rst_char_in", char_in, 8'h00);
    chk("rst_char_valid", char_valid, 0);
    chk("rst_transfer", transfer_to_row1, 0);
    chk("rst_clear", clear, 0);
    chk("rst_char_to_row2", char_to_row2, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_row2_col", row2_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_src0_ready", src0_ready, 0);
    src0_valid = 1'b0;
    rst = 1'b0;
    ev_q.delete();

    // Single character 'A': latency, pulse width and gap
    src0_valid = 1'b1; src0_data = 8'h41;
    #1;
    chk("t1_ready", src0_ready, 1);
    tick();
    src0_valid = 1'b0;
    chk("t1_stored_count", fifo_count, 1);
    chk("t1_not_yet_valid", char_valid, 0);
    tick();
    chk("t1_cv_first", char_valid, 1);
    chk("t1_char_in", char_in, 8'h41);
    chk("t1_row2_col", row2_col, 1);
    chk("t1_popped", fifo_count, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t1_cv_high", char_valid, 1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_cv_low", char_valid, 0);
    end
    chk("t1_busy_done", busy, 0);
    chk("t1_char_in_held", char_in, 8'h41);

    // Both sources continuously valid: strict alternation starting at src0
    do_reset();
    src0_valid = 1'b1; src0_data = 8'h53;
    src1_valid = 1'b1; src1_data = 8'h4D;
    got6 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (ev_q.size() >= 6) begin
        got6 = 1'b1;
        break;
      end
    end
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    chk("t2_six_emitted", got6, 1);
    for (int i = 0; i < 6; i++)
      chk("t2_order", ev_at(i), (i % 2 == 1) ? {2'd1, 8'h4D} : {2'd1, 8'h53});

    // 17 characters: row wraps with a transfer before the 17th
    do_reset();
    for (int i = 0; i < 17; i++) send(1'b0, 8'h61 + 8'(i));
    wait_idle(400);
    chk("t3_event_count", ev_q.size(), 18);
    for (int i = 0; i < 16; i++) chk("t3_char", ev_at(i), {2'd1, 8'h61 + 8'(i)});
    chk("t3_transfer", ev_at(16), {2'd2, 8'h00});
    chk("t3_last_char", ev_at(17), {2'd1, 8'h71});
    chk("t3_row2_col", row2_col, 1);

    // Newline at column 0 is discarded; 'X' + newline_req gives char then transfer
    do_reset();
    send(1'b0, 8'h0A);
    wait_idle(50);
    chk("t4_lf_no_strobe", ev_q.size(), 0);
    chk("t4_lf_drained", fifo_count, 0);
    chk("t4_lf_row", row2_col, 0);
    send(1'b0, 8'h58);
    newline_req = 1'b1;
    src0_valid = 1'b1; src0_data = 8'h55;
    #1;
    chk("t4_nl_blocks_src0", src0_ready, 0);
    tick();
    newline_req = 1'b0;
    src0_valid = 1'b0;
    wait_idle(100);
    chk("t4_event_count", ev_q.size(), 2);
    chk("t4_char_x", ev_at(0), {2'd1, 8'h58});
    chk("t4_transfer", ev_at(1), {2'd2, 8'h00});
    chk("t4_row_cleared", row2_col, 0);

    // Backpressure: fill FIFO with src0 held valid, no loss or duplication
    do_reset();
    k = 0; seen_full = 1'b0; seen_re = 1'b0;
    for (int c = 0; c < 400 && k < 12; c++) begin
      src0_valid = 1'b1;
      src0_data  = 8'h30 + 8'(k);
      #1;
      if (fifo_count == 4'd8 && !seen_full) begin
        seen_full = 1'b1;
        chk("t5_full_ready", src0_ready, 0);
      end else if (seen_full && !seen_re && src0_ready) begin
        seen_re = 1'b1;
        chk("t5_reready_count", fifo_count, 7);
      end
      if (src0_ready) k++;
      tick();
    end
    src0_valid = 1'b0;
    chk("t5_saw_full", seen_full, 1);
    chk("t5_saw_reready", seen_re, 1);
    wait_idle(400);
    chk("t5_event_count", ev_q.size(), 12);
    for (int i = 0; i < 12; i++) chk("t5_data", ev_at(i), {2'd1, 8'h30 + 8'(i)});

    // clear_req mid char_valid with 5 queued, then restart during clear
    do_reset();
    for (int i = 0; i < 7; i++) send(1'b0, 8'h61 + 8'(i));
    tick();
    tick();
    tick();
    chk("t6_pre_cv", char_valid, 1);
    chk("t6_pre_count", fifo_count, 5);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("t6_cv_forced_low", char_valid, 0);
    chk("t6_flushed", fifo_count, 0);
    chk("t6_clear_on", clear, 1);
    chk("t6_row_reset", row2_col, 0);
    chk("t6_xfer_low", transfer_to_row1, 0);
    tick();
    chk("t6_clear_2nd", clear, 1);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("t6_restart_0", clear, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("t6_restart_hold", clear, 1);
    end
    tick();
    chk("t6_clear_end", clear, 0);
    wait_idle(50);
    chk("t6_final_count", fifo_count, 0);
    chk("t6_final_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
